// File: rtl/sound_mix_sched.sv
// Time-multiplexed audio mixer: one gain multiply-accumulate per 3 MHz tick across all channels,
// followed by saturation to OUT_W bits and a one-clk sample_valid strobe.
module sound_mix_sched #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SAMPLE_DIV = 64,
  parameter int unsigned OUT_W      = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_3MHz_en,
  input  logic [NUM_CH*8-1:0]   ch_data,
  input  logic [NUM_CH*4-1:0]   ch_gain,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic                  mute,
  output logic [OUT_W-1:0]      audio_out,
  output logic                  sample_valid,
  output logic                  busy
);

  localparam int unsigned DivW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned AccW = OUT_W + 4;
  localparam int unsigned SumW = AccW + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StSat   = 2'd2;

  localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_CH - 1);
  localparam logic [AccW-1:0] OutMax  = {4'b0000, {OUT_W{1'b1}}};

  logic [1:0]          state_q;
  logic [DivW-1:0]     div_q;
  logic [IdxW-1:0]     idx_q;
  logic [AccW-1:0]     acc_q;
  logic [NUM_CH*8-1:0] data_q;
  logic [NUM_CH*4-1:0] gain_q;
  logic [NUM_CH-1:0]   en_q;
  logic                mute_q;
  logic [OUT_W-1:0]    audio_q;
  logic                valid_q;

  logic                start;
  logic [7:0]          sel_data;
  logic [3:0]          sel_gain;
  logic                sel_en;
  logic [11:0]         term;
  logic [SumW-1:0]     sum;
  logic [AccW-1:0]     acc_add;
  logic [OUT_W-1:0]    sat_val;

  assign start = clk_3MHz_en && (div_q == DivLast);

  always_comb begin
    sel_data = '0;
    sel_gain = '0;
    sel_en   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_data = data_q[i*8 +: 8];
        sel_gain = gain_q[i*4 +: 4];
        sel_en   = en_q[i];
      end
    end
    term = sel_en ? (12'(sel_data) * 12'(sel_gain)) : 12'd0;
    sum  = {1'b0, acc_q} + SumW'(term);
    // Sticky at all-ones so an oversized mix can never wrap back to a small value.
    acc_add = sum[AccW] ? {AccW{1'b1}} : sum[AccW-1:0];
    sat_val = (acc_q > OutMax) ? OutMax[OUT_W-1:0] : acc_q[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      gain_q  <= '0;
      en_q    <= '0;
      mute_q  <= 1'b0;
      audio_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clk_3MHz_en) begin
        div_q <= start ? '0 : div_q + 1'b1;
        case (state_q)
          StIdle: begin
            if (start) begin
              data_q  <= ch_data;
              gain_q  <= ch_gain;
              en_q    <= ch_enable;
              mute_q  <= mute;
              acc_q   <= '0;
              idx_q   <= '0;
              state_q <= StAccum;
            end
          end
          StAccum: begin
            acc_q <= acc_add;
            idx_q <= idx_q + 1'b1;
            if (idx_q == IdxLast) state_q <= StSat;
          end
          StSat: begin
            audio_q <= mute_q ? '0 : sat_val;
            valid_q <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign audio_out    = audio_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sound_mix_sched.sv
// Directed bench for sound_mix_sched: default build plus an OUT_W=10 build sharing the same inputs.
module tb_sound_mix_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] ch_data;
  logic [15:0] ch_gain;
  logic [3:0]  ch_enable;
  logic        mute;

  logic [13:0] audio;
  logic        valid;
  logic        busy;
  logic [9:0]  audio_s;
  logic        valid_s;
  logic        busy_s;

  int   total  = 0;
  int   passed = 0;
  logic last_sv;
  logic any_pulse;
  int   n;

  sound_mix_sched #(.NUM_CH(4), .SAMPLE_DIV(64), .OUT_W(14)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_3MHz_en  (en),
    .ch_data      (ch_data),
    .ch_gain      (ch_gain),
    .ch_enable    (ch_enable),
    .mute         (mute),
    .audio_out    (audio),
    .sample_valid (valid),
    .busy         (busy)
  );

  sound_mix_sched #(.NUM_CH(4), .SAMPLE_DIV(64), .OUT_W(10)) dut_w10 (
    .clk          (clk),
    .rst          (rst),
    .clk_3MHz_en  (en),
    .ch_data      (ch_data),
    .ch_gain      (ch_gain),
    .ch_enable    (ch_enable),
    .mute         (mute),
    .audio_out    (audio_s),
    .sample_valid (valid_s),
    .busy         (busy_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One enable clk followed by one idle clk; last_sv captures the strobe right after the enable.
  task automatic tick();
    en = 1'b1;
    @(posedge clk);
    #1;
    last_sv = valid;
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt = cnt + 1;
    end while (!last_sv && cnt < max);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mute = 1'b0;
    ch_data = '0; ch_gain = '0; ch_enable = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_audio", audio, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);

    ch_data = {4{8'h10}}; ch_gain = {4{4'h1}}; ch_enable = 4'b1111;
    rst = 1'b0;
    wait_valid(200, n);
    check("first_latency", n, 69);
    check("sum_0x10", audio, 64);
    check("pulse_width", valid, 0);
    wait_valid(200, n);
    check("period", n, 64);
    check("sum_0x10_again", audio, 64);

    // Disabled channels carry nonzero data and gain to prove they are gated.
    ch_data = {8'h55, 8'h55, 8'h55, 8'hff}; ch_gain = {4'h7, 4'h7, 4'h7, 4'hf};
    ch_enable = 4'b0001;
    wait_valid(200, n);
    check("ch0_only", audio, 3825);
    check("ch0_only_w10", audio_s, 1023);
    ch_enable = 4'b0000;
    wait_valid(200, n);
    check("all_disabled", audio, 0);

    ch_data = {4{8'hff}}; ch_gain = {4{4'hf}}; ch_enable = 4'b1111;
    wait_valid(200, n);
    check("full_scale", audio, 15300);
    check("full_scale_w10", audio_s, 1023);

    ch_data = {4{8'd10}}; ch_gain = {4{4'd2}};
    wait_valid(200, n);
    check("small_sum", audio, 80);
    check("small_sum_w10", audio_s, 80);
    ch_gain = {4'd0, 4'd2, 4'd2, 4'd2};
    wait_valid(200, n);
    check("gain_zero", audio, 60);

    // Snapshot isolation: divider sits at 5 after the SAT tick, so 58 ticks reach the start.
    ch_data = {4{8'h20}}; ch_gain = {4{4'h1}};
    repeat (58) tick();
    check("idle_before_start", busy, 0);
    tick();
    check("busy_after_start", busy, 1);
    ch_data = {4{8'h80}};
    wait_valid(20, n);
    check("sat_latency", n, 5);
    check("old_snapshot", audio, 128);
    wait_valid(200, n);
    check("new_snapshot", audio, 512);

    mute = 1'b1;
    wait_valid(200, n);
    check("mute_period", n, 64);
    check("muted", audio, 0);
    mute = 1'b0;
    wait_valid(200, n);
    check("unmuted", audio, 512);

    any_pulse = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) any_pulse = 1'b1;
    end
    check("freeze_no_pulse", any_pulse, 0);
    check("freeze_hold", audio, 512);

    repeat (58) tick();
    tick();
    tick();
    check("busy_in_accum", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_audio", audio, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    wait_valid(200, n);
    check("post_rst_latency", n, 69);
    check("post_rst_value", audio, 512);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
